// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
// State encodings, default geometry and a small helper used by the sequencer.
package mem_arb_pkg;

  // Default geometry of the shared data memory and requester buses.
  localparam int unsigned MEM_DATA_W = 8;
  localparam int unsigned MEM_ADDR_W = 8;
  localparam int unsigned MEM_DEPTH  = 32;

  // Sequencer state encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StAccess = ST_ACCESS,
    StDone   = ST_DONE
  } state_e;

  // Requester index helper: the requester that did not win this time.
  function automatic logic other_idx(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational.
// A lone request wins outright; on a tie the requester that did not win last time wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  // Decode the winner from the request pair and the previous grant.
  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = other_idx(last_grant);
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer for the shared single-port data memory.
// Each granted transaction runs IDLE -> ACCESS -> DONE: one memory access, then a one-cycle ack.
// Memory pins are decoded from registered state only, so req never reaches the memory
// combinationally.
// Optional build macro MEM_ARB_ADDR_CHECK_EN: addresses >= DEPTH are suppressed, return 0 and
// raise err0/err1 with the ack.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DEPTH  = MEM_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  // Requester 0: datapath load/store side
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  // Requester 1: loader/debug side
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  // Memory side
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rd,
`ifdef MEM_ARB_ADDR_CHECK_EN
  output logic              err0,
  output logic              err1,
`endif
  output logic              busy
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              grant_valid;
  logic              grant_idx;
  logic              addr_ok;
  logic [DATA_W-1:0] load_data;

  rr_arb2 u_rr_arb2 (
    .req         ({req1, req0}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

`ifdef MEM_ARB_ADDR_CHECK_EN
  // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DepthLimit = DEPTH[ADDR_W:0];

  // Range check on the latched address.
  always_comb begin
    addr_ok = ({1'b0, addr_q} < DepthLimit);
  end
`else
  // Without the range check every address goes to the memory's own decode.
  always_comb begin
    addr_ok = 1'b1;
  end
`endif

  // Data captured at the end of ACCESS: memory read data, or zero for a suppressed access.
  always_comb begin
    load_data = addr_ok ? mem_rd : '0;
  end

  // Next-state logic: grant and latch in IDLE, capture read data at the close of ACCESS.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          idx_d        = grant_idx;
          last_grant_d = grant_idx;
          we_d         = grant_idx ? we1    : we0;
          addr_d       = grant_idx ? addr1  : addr0;
          wdata_d      = grant_idx ? wdata1 : wdata0;
          state_d      = StAccess;
        end
      end
      StAccess: begin
        // Writes leave rdata alone; reads and suppressed accesses load the winner only.
        if (!we_q || !addr_ok) begin
          if (idx_q) begin
            rdata1_d = load_data;
          end else begin
            rdata0_d = load_data;
          end
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and request register; reset makes requester 0 win the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      idx_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Output decode from registered state; async reset forces every strobe low at once.
  always_comb begin
    mem_address = '0;
    mem_wd      = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ack0        = 1'b0;
    ack1        = 1'b0;

    unique case (state_q)
      StAccess: begin
        mem_address = addr_q;
        mem_wd      = wdata_q;
        mem_write   = we_q & addr_ok;
        mem_read    = ~we_q & addr_ok;
      end
      StDone: begin
        ack0 = ~idx_q;
        ack1 = idx_q;
      end
      default: begin
        mem_read = 1'b0;
      end
    endcase
  end

`ifdef MEM_ARB_ADDR_CHECK_EN
  // Error flags pulse with the ack; addr_q is still the latched address during DONE.
  always_comb begin
    err0 = ack0 & ~addr_ok;
    err1 = ack1 & ~addr_ok;
  end
`endif

  // Read data and busy indication.
  always_comb begin
    rdata0 = rdata0_q;
    rdata1 = rdata1_q;
    busy   = (state_q != StIdle);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a 32x8 behavioural memory.
// Table-driven single transactions, then contention, alternation and mid-access reset.
module tb_mem_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic       ack0, ack1, mem_read, mem_write, busy;
  logic [7:0] rdata0, rdata1, mem_address, mem_wd, mem_rd;
`ifdef MEM_ARB_ADDR_CHECK_EN
  logic       err0, err1;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_arbiter #(
    .DATA_W (8),
    .ADDR_W (8),
    .DEPTH  (32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req0        (req0),
    .we0         (we0),
    .addr0       (addr0),
    .wdata0      (wdata0),
    .ack0        (ack0),
    .rdata0      (rdata0),
    .req1        (req1),
    .we1         (we1),
    .addr1       (addr1),
    .wdata1      (wdata1),
    .ack1        (ack1),
    .rdata1      (rdata1),
    .mem_address (mem_address),
    .mem_wd      (mem_wd),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_rd      (mem_rd),
`ifdef MEM_ARB_ADDR_CHECK_EN
    .err0        (err0),
    .err1        (err1),
`endif
    .busy        (busy)
  );

  // Behavioural memory: async read, posedge write, low 5 address bits decoded.
  logic [7:0] mem    [32];
  logic [7:0] shadow [32];

  assign mem_rd = mem[mem_address[4:0]];

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]      = 8'(i);
      mem[31 - i] = 8'(i - 15);
    end
    forever begin
      @(posedge clock);
      if (mem_write) mem[mem_address[4:0]] <= mem_wd;
    end
  end

  typedef struct {
    logic       port;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       tbl[$];
  logic [7:0] exp_rd [2];

  function automatic vec_t mk(input logic p, input logic w, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] r, input logic e);
    vec_t v;
    v.port = p; v.we = w; v.addr = a; v.wdata = d; v.exp_rdata = r; v.exp_err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pop the scoreboard on an ack and compare it against what the DUT returned.
  task automatic take_ack(input logic port);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_empty: ack on port %0d, expected no ack", port);
    end else begin
      e = sb_q.pop_front();
      check("ack_port", 32'(port), 32'(e.port));
      check("rdata", 32'(port ? rdata1 : rdata0), 32'(e.rdata));
      exp_rd[e.port] = e.rdata;
      check("rdata_other", 32'(port ? rdata0 : rdata1), 32'(exp_rd[~port]));
`ifdef MEM_ARB_ADDR_CHECK_EN
      check("err", 32'(port ? err1 : err0), 32'(e.err));
`endif
    end
  endtask

  task automatic drive(input logic port, input logic r, input logic w, input logic [7:0] a,
                       input logic [7:0] d);
    if (port) begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  // One isolated transaction, sampled on negedges.
  task automatic run_txn(input vec_t v);
    int  cyc, nbusy, nwr, nrd;
    bit  done;
    exp_t e;
    cyc = 0; nbusy = 0; nwr = 0; nrd = 0; done = 0;
    e.port = v.port; e.rdata = v.exp_rdata; e.err = v.exp_err;
    @(negedge clock);
    sb_q.push_back(e);
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    while (!done && cyc < 10) begin
      @(negedge clock);
      cyc++;
      if (busy) nbusy++;
      if (mem_write) begin
        nwr++;
        check("mem_wd", 32'(mem_wd), 32'(v.wdata));
      end
      if (mem_read) nrd++;
      if (mem_read || mem_write) check("mem_address", 32'(mem_address), 32'(v.addr));
      if (ack0 && ack1) check("ack_both", 32'(1), 32'(0));
      if (ack0 || ack1) begin
        take_ack(ack1);
        drive(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
        done = 1;
      end
    end
    if (!done) begin
      check("ack_timeout", 32'(0), 32'(1));
      drive(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
      sb_q.delete();
    end
    check("latency", 32'(cyc), 32'(2));
    check("busy_cycles", 32'(nbusy), 32'(2));
    check("write_cycles", 32'(nwr), 32'((v.we && !v.exp_err) ? 1 : 0));
    check("read_cycles", 32'(nrd), 32'((!v.we && !v.exp_err) ? 1 : 0));
    if (v.we && !v.exp_err) shadow[v.addr[4:0]] = v.wdata;
    @(negedge clock);
    check("ack_one_cycle", 32'({ack1, ack0}), 32'(0));
    check("busy_after", 32'(busy), 32'(0));
  endtask

  initial begin
    int t0, t1, nack, cyc;
    exp_t e;

    for (int i = 0; i < 16; i++) begin
      shadow[i]      = 8'(i);
      shadow[31 - i] = 8'(i - 15);
    end
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_ack", 32'({ack1, ack0}), 32'(0));
    check("rst_rdata0", 32'(rdata0), 32'(0));
    check("rst_rdata1", 32'(rdata1), 32'(0));
    check("rst_mem_ctl", 32'({mem_read, mem_write}), 32'(0));
    check("rst_mem_address", 32'(mem_address), 32'(0));
    check("rst_mem_wd", 32'(mem_wd), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    reset = 1'b1;

    // port, we, addr, wdata, rdata of that port after the ack, err
    tbl.push_back(mk(1'b0, 1'b0, 8'd3,  8'h00, 8'h03, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'd20, 8'h00, 8'hFC, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'd31, 8'h00, 8'hF1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'd5,  8'hA5, 8'h03, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd5,  8'h00, 8'hA5, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 8'd0,  8'h77, 8'hF1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 8'd0,  8'h00, 8'h77, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd16, 8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'd15, 8'h00, 8'h0F, 1'b0));
`ifdef MEM_ARB_ADDR_CHECK_EN
    tbl.push_back(mk(1'b1, 1'b0, 8'h25, 8'h00, 8'h00, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h40, 8'h00, 8'h00, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h40, 8'h5A, 8'h00, 1'b1));
`else
    // 0x25 aliases word 5 through the memory's own decode.
    tbl.push_back(mk(1'b1, 1'b0, 8'h25, 8'h00, 8'hA5, 1'b0));
`endif
    foreach (tbl[i]) run_txn(tbl[i]);

    // Contention right after reset: requester 0 first, requester 1 three cycles later.
    do_reset();
    @(negedge clock);
    e.port = 1'b0; e.rdata = 8'h03; e.err = 1'b0; sb_q.push_back(e);
    e.port = 1'b1; e.rdata = 8'hFC; sb_q.push_back(e);
    drive(1'b0, 1'b1, 1'b0, 8'd3, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'd20, 8'h00);
    t0 = -1; t1 = -1; cyc = 0;
    while ((t0 < 0 || t1 < 0) && cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (ack0) begin t0 = cyc; take_ack(1'b0); req0 = 1'b0; end
      if (ack1) begin t1 = cyc; take_ack(1'b1); req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("contend_ack0_cycle", 32'(t0), 32'(2));
    check("contend_ack1_gap", 32'(t1 - t0), 32'(3));
    sb_q.delete();
    @(negedge clock);

    // Both held continuously: grants alternate 0,1,0,1.
    for (int k = 0; k < 2; k++) begin
      e.port = 1'b0; e.rdata = 8'h0F; sb_q.push_back(e);
      e.port = 1'b1; e.rdata = 8'hF1; sb_q.push_back(e);
    end
    drive(1'b0, 1'b1, 1'b0, 8'd15, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'd31, 8'h00);
    nack = 0; cyc = 0;
    while (nack < 4 && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (ack0 || ack1) begin
        take_ack(ack1);
        nack++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("alternate_acks", 32'(nack), 32'(4));
    check("alternate_cycles", 32'(cyc), 32'(11));
    sb_q.delete();
    @(negedge clock);

    // Reset during a write access.
    @(negedge clock);
    drive(1'b0, 1'b1, 1'b1, 8'd7, 8'h55);
    @(negedge clock);
    check("midrst_access_write", 32'(mem_write), 32'(1));
    reset = 1'b0;
    #1;
    check("midrst_mem_write", 32'(mem_write), 32'(0));
    check("midrst_ack0", 32'(ack0), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("midrst_idle", 32'({busy, ack1, ack0}), 32'(0));
    end
    run_txn(mk(1'b0, 1'b0, 8'd7, 8'h00, 8'h07, 1'b0));

    // Memory contents against the bench's own record of completed writes.
    for (int i = 0; i < 32; i++) check($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(shadow[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared single-port 32x8 data memory (async read, posedge write).
- Port 0 is the datapath/CPU load-store side and port 1 the loader/debug side. Both issue read/write transactions through a req/ack handshake.
- Round-robin fairness. Exactly one memory access per transaction.
- Drives the memory's address/wd/read/write pins and registers rd back to the winning requester.

Parameters:
- DATA_W, 8, data width of memory words and requester data buses.
- ADDR_W, 8, requester and memory address width.
- DEPTH, 32, number of implemented memory words; used by the optional range check.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- req0  in  1  requester 0 transaction request; held until ack0.
- we0  in  1  requester 0: 1 = write, 0 = read; stable while req0 high.
- addr0  in  ADDR_W  requester 0 address; stable while req0 high.
- wdata0  in  DATA_W  requester 0 write data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- rdata0  out  DATA_W  requester 0 read data; valid with ack0, held afterwards.
- req1, we1, addr1, wdata1, ack1, rdata1  —  same as above for requester 1.
- mem_address  out  ADDR_W  to memory address.
- mem_wd  out  DATA_W  to memory wd.
- mem_read  out  1  to memory read.
- mem_write  out  1  to memory write.
- mem_rd  in  DATA_W  from memory rd (combinational read).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, last_grant=1 (requester 0 wins first tie).
  - ack0=ack1=0, rdata0=rdata1=0.
  - mem_read=mem_write=0, mem_address=0, mem_wd=0.
- FSM: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any req is high at posedge, latch winner index, we, addr and wdata into a request register, then go to ACCESS.
  - Winner rules: only one req high -> that one. Both high -> the one != last_grant; last_grant updates to the winner.
- ACCESS (one cycle):
  - mem_address = latched addr.
  - mem_write = latched we; mem_wd = latched wdata.
  - mem_read = !latched we.
  - At the closing posedge: the memory performs the write, or mem_rd is captured into the winner's rdata. The other requester's rdata is unchanged. Go to DONE.
- DONE (one cycle):
  - ack of the winner = 1; all mem_* control = 0. Go to IDLE.
- mem_* outputs are decoded from registered state only; no combinational path from req to the memory.
- Latency: req sampled at edge k -> memory access during cycle k+1 -> ack high during cycle k+2. One transaction per 3 cycles.
- A req still high in the IDLE cycle after ack is a new transaction. Requesters drop req in the ack cycle to avoid a repeat.
- A req arriving while busy waits; it is never dropped.
- Write data is never reflected into rdata. A write transaction leaves rdata unchanged.
- Reset mid-ACCESS:
  - mem_write drops immediately (async); no ack is issued.
  - The in-flight write may or may not have landed; requesters must reissue.
- Address is passed unmodified (all ADDR_W bits) unless the optional feature is enabled.

Optional Feature:
- Macro: MEM_ARB_ADDR_CHECK_EN.
- Defined:
  - Latched addr >= DEPTH is out of range: ACCESS asserts neither mem_read nor mem_write, and the winner's rdata is loaded with 0.
  - Extra outputs err0/err1 (1 bit each, reset 0) pulse together with the corresponding ack.
  - In-range accesses behave as normal.
- Undefined:
  - No err ports. The address is passed through; the memory's own decode handles the upper bits.

Decomposition:
- Package mem_arb_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2.
  - Defaults DATA_W, ADDR_W, DEPTH.
- One sub-module, rr_arb2: combinational 2-way round-robin pick.
  - Inputs: req[1:0], last_grant.
  - Outputs: grant_valid, grant_idx.
- The FSM, request latch and rdata registers stay in mem_arbiter.

Test Plan (bench instantiates mem_arbiter and the 32x8 memory; memory init data[i]=i, data[31-i]=i-15):
- Read, requester 0: req0, we0=0, addr0=3 -> ack0 in 3rd cycle, rdata0=8'h03, busy high for 2 cycles, rdata1 stays 0.
- Read upper half, requester 1: addr1=20 -> rdata1=8'hFC; addr1=31 -> rdata1=8'hF1.
- Write then read, requester 0: write addr0=5, wdata0=8'hA5 -> ack0, mem_write high exactly 1 cycle. Follow-up read addr0=5 -> rdata0=8'hA5.
- Contention:
  - req0 and req1 both raised in the same cycle after reset -> requester 0 served first, ack1 exactly 3 cycles after ack0.
  - Both held continuously -> grants alternate 0,1,0,1.
- Reset mid-op: write addr0=7, wdata0=8'h55; pull reset low during ACCESS -> mem_write and ack0 go 0 asynchronously, busy=0, state IDLE after release.
- With MEM_ARB_ADDR_CHECK_EN: read addr0=8'h40 -> ack0 and err0 pulse together, rdata0=0, mem_read never asserted. Write to 8'h40 -> mem_write never asserted, all 32 words unchanged.
